wb_rr_arbiter: RTL and testbench

- Round-robin Wishbone B3 arbiter that shares one slave-side bus port (the address-decoding interconnect) among several masters: CPU, a future DMA engine and a debug master.
- Sits between the masters and the interconnect's single master port.
- Bus ownership is held for a whole cycle (cyc_i high), so bursts and read-modify-write sequences are never split.
- A per-transfer watchdog terminates transfers the slave never acknowledges and returns err to the owning master.

---
 rtl/wb_rr_arbiter.sv | 170 +++++++++++++++++
 tb/tb_wb_rr_arbiter.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_rr_arbiter.sv
// Round-robin Wishbone B3 arbiter: one owner per whole cyc, with a per-transfer ack/err watchdog.
// Latency: grant 1 cycle after a cyc request in IDLE; the request/return paths are combinational while owned.
// Backpressure: the slave stalls the owner by withholding ack; the watchdog aborts with err after TIMEOUT wait cycles.
module wb_rr_arbiter #(
  parameter int MASTERS = 2,
  parameter int DW      = 32,
  parameter int AW      = 32,
  parameter int TIMEOUT = 255
) (
  input  logic                     wb_clk_i,
  input  logic                     wb_rst_i,
  input  logic [MASTERS*AW-1:0]    m_adr_i,
  input  logic [MASTERS*DW-1:0]    m_dat_i,
  input  logic [MASTERS*(DW/8)-1:0] m_sel_i,
  input  logic [MASTERS-1:0]       m_cyc_i,
  input  logic [MASTERS-1:0]       m_stb_i,
  input  logic [MASTERS-1:0]       m_we_i,
  output logic [DW-1:0]            m_dat_o,
  output logic [MASTERS-1:0]       m_ack_o,
  output logic [MASTERS-1:0]       m_err_o,
  output logic [AW-1:0]            s_adr_o,
  output logic [DW-1:0]            s_dat_o,
  output logic [DW/8-1:0]          s_sel_o,
  output logic                     s_cyc_o,
  output logic                     s_stb_o,
  output logic                     s_we_o,
  input  logic [DW-1:0]            s_dat_i,
  input  logic                     s_ack_i,
  input  logic                     s_err_i,
  output logic [MASTERS-1:0]       grant_o,
  output logic                     timeout_o
);

  localparam int PW  = (MASTERS > 1) ? $clog2(MASTERS) : 1;
  localparam int WDW = $clog2(TIMEOUT + 1);
  localparam int SW  = DW / 8;
  localparam logic [PW-1:0]  LAST_RST = PW'(MASTERS - 1);
  localparam logic [WDW-1:0] WD_LIMIT = WDW'(TIMEOUT);

  typedef enum logic {ST_IDLE, ST_OWN} state_t;

  state_t         state_q, state_d;
  // last_q doubles as the owner index while in ST_OWN
  logic [PW-1:0]  last_q, last_d;
  logic [WDW-1:0] wd_q, wd_d;

  logic           own;
  logic           own_cyc, own_stb, own_we;
  logic [AW-1:0]  own_adr;
  logic [DW-1:0]  own_dat;
  logic [SW-1:0]  own_sel;
  logic [PW-1:0]  pick;
  logic           any_req;
  logic           abort;

  assign own     = (state_q == ST_OWN);
  assign any_req = |m_cyc_i;

  // Select the owner's request signals out of the packed master buses
  always_comb begin
    own_cyc = 1'b0;
    own_stb = 1'b0;
    own_we  = 1'b0;
    own_adr = '0;
    own_dat = '0;
    own_sel = '0;
    for (int k = 0; k < MASTERS; k++) begin
      if (last_q == PW'(k)) begin
        own_cyc = m_cyc_i[k];
        own_stb = m_stb_i[k];
        own_we  = m_we_i[k];
        own_adr = m_adr_i[k*AW +: AW];
        own_dat = m_dat_i[k*DW +: DW];
        own_sel = m_sel_i[k*SW +: SW];
      end
    end
  end

  // Round-robin pick: first requester scanning upward from last_q+1, wrapping
  always_comb begin
    logic found;
    int   idx;
    found = 1'b0;
    idx   = 0;
    pick  = last_q;
    for (int i = 1; i <= MASTERS; i++) begin
      idx = (int'(last_q) + i) % MASTERS;
      if (!found && m_cyc_i[PW'(idx)]) begin
        found = 1'b1;
        pick  = PW'(idx);
      end
    end
  end

  // Abort ignores ack/err of its own cycle: the slave already sees stb low, so any
  // ack there is late, and this keeps s_stb_o free of a combinational ack loop.
  assign abort = own && own_stb && (wd_q == WD_LIMIT);

  // State register, owner pointer and watchdog
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q <= ST_IDLE;
      last_q  <= LAST_RST;
      wd_q    <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      wd_q    <= wd_d;
    end
  end

  // Next-state: grant on any request in IDLE, release when the owner drops cyc
  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    case (state_q)
      ST_IDLE: begin
        if (any_req) begin
          state_d = ST_OWN;
          last_d  = pick;
        end
      end
      ST_OWN: begin
        if (!own_cyc) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Watchdog: count wait cycles of a strobed transfer, saturating at TIMEOUT
  always_comb begin
    wd_d = wd_q;
    if (!own || !own_cyc || !own_stb || s_ack_i || s_err_i || abort) begin
      wd_d = '0;
    end else if (wd_q != WD_LIMIT) begin
      wd_d = wd_q + WDW'(1);
    end
  end

  // Outputs: slave-side mux and per-master returns, all gated by ownership
  always_comb begin
    grant_o   = '0;
    s_adr_o   = '0;
    s_dat_o   = '0;
    s_sel_o   = '0;
    s_we_o    = 1'b0;
    s_cyc_o   = 1'b0;
    s_stb_o   = 1'b0;
    m_ack_o   = '0;
    m_err_o   = '0;
    timeout_o = 1'b0;
    m_dat_o   = s_dat_i;
    if (own) begin
      grant_o = {{(MASTERS-1){1'b0}}, 1'b1} << last_q;
      s_adr_o = own_adr;
      s_dat_o = own_dat;
      s_sel_o = own_sel;
      s_we_o  = own_we;
      s_cyc_o = own_cyc && !abort;
      s_stb_o = own_stb && !abort;
      // A reset cycle delivers no ack/err; the grant drops on the following edge
      if (!wb_rst_i) begin
        m_ack_o   = grant_o & m_stb_i & {MASTERS{s_ack_i && !abort}};
        m_err_o   = grant_o & (({MASTERS{s_err_i}} & m_stb_i) | {MASTERS{abort}});
        timeout_o = abort;
      end
    end
  end

endmodule

// File: tb/tb_wb_rr_arbiter.sv
// Directed bench for wb_rr_arbiter (2 masters, TIMEOUT=8) with hand-computed expectations.
// Inputs change 1 time unit after the rising edge; outputs are checked 1 unit later.
// The slave is modelled by directly driving s_ack_i / s_err_i per cycle.
module tb_wb_rr_arbiter;
  localparam int M  = 2;
  localparam int DW = 32;
  localparam int AW = 32;
  localparam int TO = 8;

  logic              clk = 1'b0;
  logic              rst;
  logic [M*AW-1:0]   m_adr;
  logic [M*DW-1:0]   m_dat;
  logic [M*DW/8-1:0] m_sel;
  logic [M-1:0]      m_cyc, m_stb, m_we;
  logic [DW-1:0]     m_dat_o;
  logic [M-1:0]      m_ack, m_err;
  logic [AW-1:0]     s_adr;
  logic [DW-1:0]     s_dat_o;
  logic [DW/8-1:0]   s_sel;
  logic              s_cyc, s_stb, s_we;
  logic [DW-1:0]     s_dat_i;
  logic              s_ack, s_err;
  logic [M-1:0]      grant;
  logic              tmo;

  int n_chk = 0;
  int n_err = 0;

  localparam logic [AW-1:0] ADR0 = 32'h1000_0040;
  localparam logic [AW-1:0] ADR1 = 32'h2000_0080;
  localparam logic [DW-1:0] DAT0 = 32'hA5A5_0001;
  localparam logic [DW-1:0] DAT1 = 32'h5A5A_0002;

  always #5 clk = ~clk;

  wb_rr_arbiter #(.MASTERS(M), .DW(DW), .AW(AW), .TIMEOUT(TO)) dut (
    .wb_clk_i (clk),
    .wb_rst_i (rst),
    .m_adr_i  (m_adr),
    .m_dat_i  (m_dat),
    .m_sel_i  (m_sel),
    .m_cyc_i  (m_cyc),
    .m_stb_i  (m_stb),
    .m_we_i   (m_we),
    .m_dat_o  (m_dat_o),
    .m_ack_o  (m_ack),
    .m_err_o  (m_err),
    .s_adr_o  (s_adr),
    .s_dat_o  (s_dat_o),
    .s_sel_o  (s_sel),
    .s_cyc_o  (s_cyc),
    .s_stb_o  (s_stb),
    .s_we_o   (s_we),
    .s_dat_i  (s_dat_i),
    .s_ack_i  (s_ack),
    .s_err_i  (s_err),
    .grant_o  (grant),
    .timeout_o(tmo)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic do_reset();
    m_cyc = '0;
    m_stb = '0;
    s_ack = 1'b0;
    s_err = 1'b0;
    rst   = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

  initial begin
    m_adr   = {ADR1, ADR0};
    m_dat   = {DAT1, DAT0};
    m_sel   = 8'h3F;
    m_we    = 2'b01;
    s_dat_i = 32'hCAFE_F00D;

    // ---- reset state ----
    do_reset();
    settle();
    check("rst_grant", 64'(grant), 64'(2'b00));
    check("rst_scyc",  64'(s_cyc), 64'(1'b0));
    check("rst_sstb",  64'(s_stb), 64'(1'b0));
    check("rst_sadr",  64'(s_adr), 64'(32'h0));
    check("rst_ackerr", 64'({m_ack, m_err, tmo}), 64'(5'b0));

    // ---- single master0 transfer, ack at cycle 3 ----
    m_cyc = 2'b01; m_stb = 2'b01;
    settle();
    check("t1_c0_grant", 64'(grant), 64'(2'b00));
    tick(); settle();
    check("t1_c1_grant", 64'(grant), 64'(2'b01));
    check("t1_c1_sadr",  64'(s_adr), 64'(ADR0));
    check("t1_c1_sdat",  64'(s_dat_o), 64'(DAT0));
    check("t1_c1_ssel",  64'(s_sel), 64'(4'hF));
    check("t1_c1_swe",   64'(s_we), 64'(1'b1));
    check("t1_c1_cycstb", 64'({s_cyc, s_stb}), 64'(2'b11));
    tick(); settle();
    check("t1_c2_ack", 64'(m_ack), 64'(2'b00));
    tick();
    s_ack = 1'b1; settle();
    check("t1_c3_ack",  64'(m_ack), 64'(2'b01));
    check("t1_c3_mdat", 64'(m_dat_o), 64'(32'hCAFE_F00D));
    tick();
    s_ack = 1'b0; m_cyc = 2'b00; m_stb = 2'b00; settle();
    check("t1_c4_ack",   64'(m_ack), 64'(2'b00));
    check("t1_c4_scyc",  64'(s_cyc), 64'(1'b0));
    check("t1_c4_grant", 64'(grant), 64'(2'b01));
    tick(); settle();
    check("t1_c5_grant", 64'(grant), 64'(2'b00));

    // ---- both masters, alternation with idle gap ----
    do_reset();
    m_cyc = 2'b11; m_stb = 2'b11; settle();
    check("t2_c0_grant", 64'(grant), 64'(2'b00));
    tick();
    s_ack = 1'b1; settle();
    check("t2_c1_grant", 64'(grant), 64'(2'b01));
    check("t2_c1_ack",   64'(m_ack), 64'(2'b01));
    tick();
    s_ack = 1'b0; m_cyc = 2'b10; m_stb = 2'b10; settle();
    check("t2_c2_grant", 64'(grant), 64'(2'b01));
    check("t2_c2_scyc",  64'(s_cyc), 64'(1'b0));
    tick();
    m_cyc = 2'b11; m_stb = 2'b11; settle();
    check("t2_c3_grant", 64'(grant), 64'(2'b00));
    tick();
    s_ack = 1'b1; settle();
    check("t2_c4_grant", 64'(grant), 64'(2'b10));
    check("t2_c4_ack",   64'(m_ack), 64'(2'b10));
    check("t2_c4_sadr",  64'(s_adr), 64'(ADR1));
    tick();
    s_ack = 1'b0; m_cyc = 2'b01; m_stb = 2'b01; settle();
    check("t2_c5_grant", 64'(grant), 64'(2'b10));
    tick();
    m_cyc = 2'b11; m_stb = 2'b11; settle();
    check("t2_c6_grant", 64'(grant), 64'(2'b00));
    tick(); settle();
    check("t2_c7_grant", 64'(grant), 64'(2'b01));

    // ---- master1 4-beat burst while master0 waits ----
    do_reset();
    m_cyc = 2'b10; m_stb = 2'b10; settle();
    check("t3_c0_grant", 64'(grant), 64'(2'b00));
    tick();
    m_cyc = 2'b11; m_stb = 2'b11; s_ack = 1'b1; settle();
    check("t3_c1_grant", 64'(grant), 64'(2'b10));
    check("t3_c1_ack",   64'(m_ack), 64'(2'b10));
    for (int b = 1; b < 4; b++) begin
      tick();
      m_stb = 2'b01; settle();
      check("t3_gap_ack",   64'(m_ack), 64'(2'b00));
      check("t3_gap_grant", 64'(grant), 64'(2'b10));
      tick();
      m_stb = 2'b11; settle();
      check("t3_beat_ack", 64'(m_ack), 64'(2'b10));
    end
    tick();
    m_cyc = 2'b01; m_stb = 2'b01; s_ack = 1'b0; settle();
    check("t3_c8_grant", 64'(grant), 64'(2'b10));
    check("t3_c8_scyc",  64'(s_cyc), 64'(1'b0));
    tick(); settle();
    check("t3_c9_grant", 64'(grant), 64'(2'b00));
    tick(); settle();
    check("t3_c10_grant", 64'(grant), 64'(2'b01));
    check("t3_c10_sadr",  64'(s_adr), 64'(ADR0));

    // ---- watchdog abort with TIMEOUT=8 ----
    do_reset();
    m_cyc = 2'b01; m_stb = 2'b01;
    for (int c = 1; c <= 8; c++) begin
      tick(); settle();
      check("t4_wait", 64'({tmo, m_err, s_stb}), 64'(4'b0001));
    end
    tick();
    s_ack = 1'b1; settle();
    check("t4_abort_err",   64'(m_err), 64'(2'b01));
    check("t4_abort_tmo",   64'(tmo), 64'(1'b1));
    check("t4_abort_stb",   64'({s_cyc, s_stb}), 64'(2'b00));
    check("t4_abort_ack",   64'(m_ack), 64'(2'b00));
    check("t4_abort_grant", 64'(grant), 64'(2'b01));
    tick();
    s_ack = 1'b0; m_stb = 2'b00; settle();
    check("t4_post_grant", 64'(grant), 64'(2'b01));
    check("t4_post_tmo",   64'({tmo, m_err}), 64'(3'b000));
    tick();
    m_stb = 2'b01; settle();
    check("t4_rewait", 64'({tmo, m_err, s_stb}), 64'(4'b0001));
    for (int c = 1; c < 8; c++) begin
      tick(); settle();
      check("t4_rewait", 64'({tmo, m_err, s_stb}), 64'(4'b0001));
    end
    tick(); settle();
    check("t4_reabort", 64'({tmo, m_err, s_stb}), 64'(4'b1010));

    // ---- slave error on master1 ----
    do_reset();
    m_cyc = 2'b10; m_stb = 2'b10;
    tick();
    m_cyc = 2'b11; m_stb = 2'b11; s_err = 1'b1; settle();
    check("t5_grant", 64'(grant), 64'(2'b10));
    check("t5_err",   64'(m_err), 64'(2'b10));
    check("t5_ack",   64'(m_ack), 64'(2'b00));
    check("t5_tmo",   64'(tmo), 64'(1'b0));
    tick();
    s_err = 1'b0; m_cyc = 2'b01; m_stb = 2'b01; settle();
    check("t5_err_clr", 64'(m_err), 64'(2'b00));

    // ---- reset mid-transfer while master1 owns ----
    do_reset();
    m_cyc = 2'b10; m_stb = 2'b10;
    tick(); settle();
    check("t6_own", 64'(grant), 64'(2'b10));
    tick();
    rst = 1'b1; s_ack = 1'b1; settle();
    check("t6_rst_ack", 64'({m_ack, m_err}), 64'(4'b0000));
    tick();
    rst = 1'b0; s_ack = 1'b0; m_cyc = 2'b11; m_stb = 2'b11; settle();
    check("t6_after_grant", 64'(grant), 64'(2'b00));
    check("t6_after_slave", 64'({s_cyc, s_stb, s_we}), 64'(3'b000));
    check("t6_after_sadr",  64'(s_adr), 64'(32'h0));
    check("t6_after_ret",   64'({m_ack, m_err, tmo}), 64'(5'b0));
    tick(); settle();
    check("t6_regrant",      64'(grant), 64'(2'b01));
    check("t6_regrant_sadr", 64'(s_adr), 64'(ADR0));

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
